radio_timing_sequencer: RTL and testbench

- Consumer end of the timing-engine radio-enable path. Takes synchronised `radioEnableSynced`/`radioRxEnSynced` plus `pllSettled` and the SPI-programmed `tArstFs` delay.
- Produces the staged radio enables `radioEnable1`/`radioRxEn1` (stage 1) and `radioEnable2`/`radioRxEn2` (stage 2), with ordered power-up and reverse-order power-down.
- Sits directly after the enable synchroniser in the timing engine.

---
 rtl/pa_RadioSeq.sv | 26 ++
 rtl/radio_timing_sequencer_if.sv | 30 +++
 rtl/radio_seq_dly_cnt.sv | 27 ++
 rtl/radio_timing_sequencer.sv | 178 +++++++++++++++++
 tb/tb_radio_timing_sequencer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/pa_RadioSeq.sv
// Shared types and sizing helpers for the radio timing sequencer.
// The state encoding and counter width are shared by the top level and its down-counter.
package pa_RadioSeq;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PLL  = 3'd1,
    ARST_DLY  = 3'd2,
    STAGE1    = 3'd3,
    ACTIVE    = 3'd4,
    RAMP_DOWN = 3'd5,
    LOCKOUT   = 3'd6
  } state_t;

  // The counter must hold tArstFs, STAGE2_DLY-1 and PLL_TIMEOUT-1.
  function automatic int cnt_width(input int t_w, input int stage2_dly, input int pll_timeout);
    int w;
    w = t_w;
    if ($clog2(stage2_dly) > w) w = $clog2(stage2_dly);
    if ($clog2(pll_timeout) > w) w = $clog2(pll_timeout);
    return w;
  endfunction

  localparam int CNT_W_DEFAULT = cnt_width(8, 4, 200);

endpackage

// File: rtl/radio_timing_sequencer_if.sv
// Request/status bundle between the enable synchroniser and the radio timing sequencer.
interface radio_timing_sequencer_if #(
  parameter int SIZE_SPISLAVE_T_ARSTFS = 8
);

  logic                              radioEnableSynced;
  logic                              radioRxEnSynced;
  logic                              pllSettled;
  logic [SIZE_SPISLAVE_T_ARSTFS-1:0] tArstFs;
  logic                              radioEnable1;
  logic                              radioRxEn1;
  logic                              radioEnable2;
  logic                              radioRxEn2;
  logic                              busy;
  logic                              pllTimeoutErr;
  logic                              pllLostErr;

  modport master (
    output radioEnableSynced, radioRxEnSynced, pllSettled, tArstFs,
    input  radioEnable1, radioRxEn1, radioEnable2, radioRxEn2,
    input  busy, pllTimeoutErr, pllLostErr
  );

  modport slave (
    input  radioEnableSynced, radioRxEnSynced, pllSettled, tArstFs,
    output radioEnable1, radioRxEn1, radioEnable2, radioRxEn2,
    output busy, pllTimeoutErr, pllLostErr
  );

endinterface

// File: rtl/radio_seq_dly_cnt.sv
// Loadable down-counter shared by every timed state of the radio sequencer.
module radio_seq_dly_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/radio_timing_sequencer.sv
// Staged radio enable sequencer: ordered power-up after PLL lock, reverse-order power-down.
// Define RADIO_SEQ_PLL_LOSS_EN to force LOCKOUT when the PLL drops while the radio is up.
module radio_timing_sequencer
  import pa_RadioSeq::*;
#(
  parameter int SIZE_SPISLAVE_T_ARSTFS = 8,
  parameter int STAGE2_DLY             = 4,
  parameter int PLL_TIMEOUT            = 200
) (
  input  logic                     clk,
  input  logic                     resetN,
  radio_timing_sequencer_if.slave  bus
);

  localparam int CNT_W = cnt_width(SIZE_SPISLAVE_T_ARSTFS, STAGE2_DLY, PLL_TIMEOUT);

  state_t             state;
  state_t             nxt;
  logic               rx_mode;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;
  logic [CNT_W-1:0]   cnt_val;
  logic               loss_hit;
  logic               en;
  logic               tmo_err;
  logic               en1;
  logic               rx1;
  logic               en2;
  logic               rx2;
  logic               busy_q;

  assign en = bus.radioEnableSynced;

  radio_seq_dly_cnt #(.W(CNT_W)) u_dly_cnt (
    .clk      (clk),
    .rst_n    (resetN),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    nxt      = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    loss_hit = 1'b0;
`ifdef RADIO_SEQ_PLL_LOSS_EN
    loss_hit = !bus.pllSettled && (state inside {ARST_DLY, STAGE1, ACTIVE});
`endif
    case (state)
      IDLE: begin
        if (en) begin
          nxt      = WAIT_PLL;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(PLL_TIMEOUT - 1);
        end
      end
      WAIT_PLL: begin
        if (!en) begin
          nxt = IDLE;
        end else if (bus.pllSettled) begin
          nxt      = ARST_DLY;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(bus.tArstFs);
        end else if (cnt_zero) begin
          nxt = LOCKOUT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ARST_DLY: begin
        if (loss_hit) begin
          nxt = LOCKOUT;
        end else if (!en) begin
          nxt = IDLE;
        end else if (cnt_zero) begin
          nxt      = STAGE1;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(STAGE2_DLY - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      STAGE1: begin
        if (loss_hit) begin
          nxt = LOCKOUT;
        end else if (!en) begin
          // Stage 2 never came up, so stage 1 can drop on the very next edge.
          nxt      = RAMP_DOWN;
          cnt_load = 1'b1;
          cnt_val  = '0;
        end else if (cnt_zero) begin
          nxt = ACTIVE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ACTIVE: begin
        if (loss_hit) begin
          nxt = LOCKOUT;
        end else if (!en) begin
          nxt      = RAMP_DOWN;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(STAGE2_DLY - 1);
        end
      end
      RAMP_DOWN: begin
        if (cnt_zero) begin
          nxt = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      LOCKOUT: begin
        if (!en) begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      rx_mode <= 1'b0;
      tmo_err <= 1'b0;
      busy_q  <= 1'b0;
      en1     <= 1'b0;
      rx1     <= 1'b0;
      en2     <= 1'b0;
      rx2     <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && nxt == WAIT_PLL) begin
        rx_mode <= bus.radioRxEnSynced;
        tmo_err <= 1'b0;
      end else if (state == WAIT_PLL && nxt == LOCKOUT) begin
        tmo_err <= 1'b1;
      end
      busy_q <= (nxt != IDLE);
      en1    <= (nxt inside {STAGE1, ACTIVE, RAMP_DOWN});
      rx1    <= (nxt inside {STAGE1, ACTIVE, RAMP_DOWN}) && rx_mode;
      en2    <= (nxt == ACTIVE);
      rx2    <= (nxt == ACTIVE) && rx_mode;
    end
  end

`ifdef RADIO_SEQ_PLL_LOSS_EN
  logic lost_err;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lost_err <= 1'b0;
    end else if (state == IDLE && nxt == WAIT_PLL) begin
      lost_err <= 1'b0;
    end else if (loss_hit) begin
      lost_err <= 1'b1;
    end
  end

  assign bus.pllLostErr = lost_err;
`else
  assign bus.pllLostErr = 1'b0;
`endif

  assign bus.radioEnable1  = en1;
  assign bus.radioRxEn1    = rx1;
  assign bus.radioEnable2  = en2;
  assign bus.radioRxEn2    = rx2;
  assign bus.busy          = busy_q;
  assign bus.pllTimeoutErr = tmo_err;

endmodule

// File: tb/tb_radio_timing_sequencer.sv
// Scoreboard bench for radio_timing_sequencer: per-cycle expected outputs derived from the latency rules.
module tb_radio_timing_sequencer;

  logic clk;
  logic resetN;
  logic [6:0] sb [$];
  string phase;
  int checks;
  int failures;
  logic [7:0] t_cur;

  radio_timing_sequencer_if #(.SIZE_SPISLAVE_T_ARSTFS(8)) bus ();

  radio_timing_sequencer #(
    .SIZE_SPISLAVE_T_ARSTFS (8),
    .STAGE2_DLY             (4),
    .PLL_TIMEOUT            (10)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ev(input bit b, input bit t, input bit l,
                                    input bit e1, input bit r1, input bit e2, input bit r2);
    return {b, t, l, e1, r1, e2, r2};
  endfunction

  function automatic logic [6:0] outv();
    return {bus.busy, bus.pllTimeoutErr, bus.pllLostErr,
            bus.radioEnable1, bus.radioRxEn1, bus.radioEnable2, bus.radioRxEn2};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit en, input bit rx, input bit pll, input logic [6:0] exp);
    @(negedge clk);
    bus.radioEnableSynced = en;
    bus.radioRxEnSynced   = rx;
    bus.pllSettled        = pll;
    bus.tArstFs           = t_cur;
    sb.push_back(exp);
    @(posedge clk);
  endtask

  // Disable sampled at j=0: stage 2 drops at once, stage 1 four edges later.
  task automatic ramp(input bit rx, input bit pll);
    for (int j = 0; j < 6; j++)
      step(1'b0, rx, pll, ev(j < 4, 0, 0, j < 4, rx && (j < 4), 0, 0));
  endtask

  always @(posedge clk) begin
    logic [6:0] o;
    #1;
    o = outv();
    check_val("invariant", {29'd0, o[1] & ~o[3], o[2] & ~o[3], o[0] & ~o[1]}, 32'd0);
    if (sb.size() != 0) check_val(phase, {25'd0, o}, {25'd0, sb.pop_front()});
  end

  initial begin
    checks   = 0;
    failures = 0;
    t_cur    = 8'd0;
    phase    = "reset";
    resetN   = 1'b0;
    bus.radioEnableSynced = 1'b0;
    bus.radioRxEnSynced   = 1'b0;
    bus.pllSettled        = 1'b0;
    bus.tArstFs           = 8'd0;
    #12;
    check_val("reset_outputs", {25'd0, outv()}, 32'd0);
    @(negedge clk);
    resetN = 1'b1;
    step(1'b0, 1'b0, 1'b1, ev(0, 0, 0, 0, 0, 0, 0));

    phase = "presettled_t3_rx";
    t_cur = 8'd3;
    for (int k = 0; k < 13; k++)
      step(1'b1, 1'b1, 1'b1, ev(1, 0, 0, k >= 5, k >= 5, k >= 9, k >= 9));
    phase = "ramp_t3_rx";
    ramp(1'b1, 1'b1);

    phase = "t0_tx";
    t_cur = 8'd0;
    for (int k = 0; k < 9; k++)
      step(1'b1, 1'b0, 1'b1, ev(1, 0, 0, k >= 2, 0, k >= 6, 0));
    phase = "ramp_t0_tx";
    ramp(1'b0, 1'b1);

    phase = "pll_timeout";
    t_cur = 8'd3;
    for (int k = 0; k < 15; k++)
      step(1'b1, 1'b1, 1'b0, ev(1, k >= 10, 0, 0, 0, 0, 0));
    phase = "lockout_exit";
    step(1'b0, 1'b1, 1'b0, ev(0, 1, 0, 0, 0, 0, 0));
    step(1'b0, 1'b1, 1'b0, ev(0, 1, 0, 0, 0, 0, 0));
    phase = "retry_clears_err";
    t_cur = 8'd0;
    for (int k = 0; k < 3; k++)
      step(1'b1, 1'b0, 1'b1, ev(1, 0, 0, k >= 2, 0, 0, 0));
    phase = "abort_stage1";
    step(1'b0, 1'b0, 1'b1, ev(1, 0, 0, 1, 0, 0, 0));
    step(1'b0, 1'b0, 1'b1, ev(0, 0, 0, 0, 0, 0, 0));

    phase = "abort_arst";
    t_cur = 8'd50;
    for (int k = 0; k < 6; k++)
      step(1'b1, 1'b1, 1'b1, ev(1, 0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b1, 1'b1, ev(0, 0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b1, 1'b1, ev(0, 0, 0, 0, 0, 0, 0));

    phase = "rx_toggle_active";
    t_cur = 8'd1;
    for (int k = 0; k < 10; k++)
      step(1'b1, 1'b1, 1'b1, ev(1, 0, 0, k >= 3, k >= 3, k >= 7, k >= 7));
    for (int k = 0; k < 4; k++)
      step(1'b1, k[0], 1'b1, ev(1, 0, 0, 1, 1, 1, 1));

    phase = "pll_pulse_active";
`ifdef RADIO_SEQ_PLL_LOSS_EN
    step(1'b1, 1'b1, 1'b0, ev(1, 0, 1, 0, 0, 0, 0));
    step(1'b1, 1'b1, 1'b1, ev(1, 0, 1, 0, 0, 0, 0));
    step(1'b0, 1'b1, 1'b1, ev(0, 0, 1, 0, 0, 0, 0));
    step(1'b0, 1'b1, 1'b1, ev(0, 0, 1, 0, 0, 0, 0));
`else
    step(1'b1, 1'b1, 1'b0, ev(1, 0, 0, 1, 1, 1, 1));
    step(1'b1, 1'b1, 1'b1, ev(1, 0, 0, 1, 1, 1, 1));
    ramp(1'b1, 1'b1);
`endif

    phase = "pre_async_reset";
    t_cur = 8'd0;
    for (int k = 0; k < 8; k++)
      step(1'b1, 1'b1, 1'b1, ev(1, 0, 0, k >= 2, k >= 2, k >= 6, k >= 6));
    #3;
    resetN = 1'b0;
    #1;
    check_val("async_reset_drop", {25'd0, outv()}, 32'd0);
    @(negedge clk);
    bus.radioEnableSynced = 1'b0;
    repeat (2) @(negedge clk);
    check_val("async_reset_hold", {25'd0, outv()}, 32'd0);
    resetN = 1'b1;

    phase = "after_reset_t2_tx";
    t_cur = 8'd2;
    for (int k = 0; k < 11; k++)
      step(1'b1, 1'b0, 1'b1, ev(1, 0, 0, k >= 4, 0, k >= 8, 0));
    phase = "ramp_t2_tx";
    ramp(1'b0, 1'b1);

    repeat (2) @(posedge clk);
    #2;
    check_val("sb_drain", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
